fork_two_outputs: RTL
=====================

# fork_two_outputs

Stream fork for the FM radio datapath: pops one signed 32-bit sample from an input FIFO and pushes a copy into each of two output FIFOs, A and B. Each output has its own independent handshake. It is the producer-side counterpart of the two-input combiners: one stream, such as the demodulated baseband, fans out to two consumers, such as parallel filter chains. Branch B optionally carries a fixed quantized gain.

## Interface
- DATA_WIDTH, 32: sample width (signed).
- QUANT_BITS, 10: fixed-point fraction bits for dequantization.
- GAIN_B, 32'sd512: signed quantized gain applied to branch B (512 = 0.5). Used only when FORK_GAIN_EN is defined.
- clock  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-high reset.
- in_rd_en  out  1: pop strobe to input FIFO.
- in_empty  in  1: input FIFO empty.
- in_dout  in  DATA_WIDTH: input head word (first-word fall-through; valid whenever !in_empty).
- outA_wr_en  out  1: push strobe to FIFO A.
- outA_full  in  1: FIFO A full.
- outA_din  out  DATA_WIDTH: data to FIFO A.
- outB_wr_en  out  1: push strobe to FIFO B.
- outB_full  in  1: FIFO B full.
- outB_din  out  DATA_WIDTH: data to FIFO B.

## Operation
- Registers: state (S_READ, S_WRITE); dataA; dataB; sentA; sentB.
- Reset:
  - state = S_READ; dataA = dataB = 0; sentA = sentB = 0.
  - All outputs (in_rd_en, outA_wr_en, outB_wr_en, outA_din, outB_din) are 0.
- S_READ: if !in_empty, do a capture, then go to S_WRITE. Otherwise hold.
- Capture:
  - Assert in_rd_en; dataA <= in_dout.
  - dataB <= branch-B value of in_dout.
  - sentA <= 0; sentB <= 0.
- S_WRITE:
  - needA = !sentA; needB = !sentB.
  - If needA && !outA_full: assert outA_wr_en with outA_din = dataA, and set sentA.
  - B is handled the same way, independently. Both writes may occur in the same cycle.
  - done = (sentA or A written this cycle) && (sentB or B written this cycle).
  - If done && !in_empty: capture the next sample in the same cycle and stay in S_WRITE (back-to-back).
  - If done && in_empty: go to S_READ.
  - Otherwise stay in S_WRITE.
- A stalled branch never blocks the other branch's pending write for the current sample. No new sample is read until both copies are delivered.
- outX_din is driven with dataX only while outX_wr_en is high; otherwise it is 0.
- Samples are never dropped, duplicated or reordered on either branch.

## Timing
- Latency: input popped in cycle N gives earliest writes in cycle N+1 on both branches.
- Throughput: one sample per cycle sustained when both outputs are not full and the input is not empty; the first sample after idle costs one extra cycle.
- Back-pressure: if B stays full for k cycles, A completes and the block then idles in S_WRITE with in_rd_en = 0 until B accepts.
- Simultaneous release: when outA_full and outB_full both drop in the same cycle, both writes occur in that cycle.
- Reset mid-operation: a pending sample is discarded, and all strobes are low from the reset edge onward.

## Configuration
- FORK_GAIN_EN defined: dataB = DEQUANTIZE(in_dout * GAIN_B).
  - The product is a 64-bit signed multiply.
  - It is divided by 2^QUANT_BITS, truncating toward zero (not an arithmetic shift).
  - The low DATA_WIDTH bits are kept.
  - The multiply is computed in the capture cycle and registered; latency is unchanged.
- FORK_GAIN_EN undefined: dataB = in_dout; no multiplier is inferred and GAIN_B is ignored.

## Structure
- The shared FM radio package holds:
  - QUANT_BITS default.
  - The DEQUANTIZE function (signed, truncate toward zero), shared with the multiply and combiner blocks.
  - The fork state_t enum.
- Single module; no sub-module. The gain is an inline package-function call.

## Test plan
- Basic fork, FORK_GAIN_EN off: input 0x00000400 then 0xFFFFFFFD. Required: A receives 0x400, 0xFFFFFFFD; B receives the same values; first writes occur 1 cycle after the pop.
- Gain with FORK_GAIN_EN on, GAIN_B = 512: inputs 1024, -3, 7.
  - A receives 1024, -3, 7.
  - B receives 512, -1, 3. This checks truncation toward zero: -1536/1024 must give -1, not -2.
- Streaming: 16 samples 0..15 preloaded, both outputs never full. Required: in_rd_en high 16 consecutive cycles; both outputs receive 0..15 in order, one per cycle.
- Asymmetric stall: outB_full held high for 5 cycles while 3 samples are queued. Required:
  - A receives sample 0 only.
  - No second pop occurs until B accepts sample 0.
  - Both branches finally hold all 3 samples in order.
- Simultaneous release: both full for 4 cycles, then both drop. Required: outA_wr_en and outB_wr_en assert in the same cycle.
- Reset mid-operation: assert reset while in S_WRITE with A sent and B pending. Required: all outputs 0 immediately; after release, the next pop is a fresh sample and no stale B write occurs.

Source files
------------

// File: rtl/fork_two_outputs_pkg.sv
// Shared FM radio definitions: quantization default, dequantize helper, fork FSM states.
package fork_two_outputs_pkg;

    localparam int QUANT_BITS_DEFAULT = 10;

    typedef enum logic [0:0] {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // Signed divide by 2^qbits rounding toward zero: bias negatives before the shift.
    function automatic logic signed [63:0] dequantize(input logic signed [63:0] value,
                                                      input int qbits);
        logic signed [63:0] bias;
        bias = value[63] ? ((64'sd1 <<< qbits) - 64'sd1) : 64'sd0;
        return (value + bias) >>> qbits;
    endfunction

endpackage

// File: rtl/fork_two_outputs.sv
// Stream fork: one input FIFO fans out to FIFOs A and B with independent handshakes.
// Define FORK_GAIN_EN to scale branch B by GAIN_B (fixed point, QUANT_BITS fraction bits).
module fork_two_outputs
    import fork_two_outputs_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 QUANT_BITS = QUANT_BITS_DEFAULT,
    parameter logic signed [31:0] GAIN_B     = 32'sd512
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  outA_wr_en,
    input  logic                  outA_full,
    output logic [DATA_WIDTH-1:0] outA_din,
    output logic                  outB_wr_en,
    input  logic                  outB_full,
    output logic [DATA_WIDTH-1:0] outB_din
);

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] data_a_reg;
    logic [DATA_WIDTH-1:0] data_b_reg;
    logic                  sent_a_reg;
    logic                  sent_b_reg;

    logic                  write_a;
    logic                  write_b;
    logic                  done;
    logic                  capture;
    logic [DATA_WIDTH-1:0] branch_b_value;

`ifdef FORK_GAIN_EN
    logic signed [63:0] product;
    logic signed [63:0] scaled;

    assign product        = 64'($signed(in_dout)) * 64'(GAIN_B);
    assign scaled         = dequantize(product, QUANT_BITS);
    assign branch_b_value = scaled[DATA_WIDTH-1:0];
`else
    assign branch_b_value = in_dout;
`endif

    // Strobes are gated by reset so nothing leaks out while reset is held.
    assign write_a = !reset && (state_reg == S_WRITE) && !sent_a_reg && !outA_full;
    assign write_b = !reset && (state_reg == S_WRITE) && !sent_b_reg && !outB_full;
    assign done    = (sent_a_reg || write_a) && (sent_b_reg || write_b);
    assign capture = !reset && !in_empty && ((state_reg == S_READ) || done);

    assign in_rd_en   = capture;
    assign outA_wr_en = write_a;
    assign outB_wr_en = write_b;
    assign outA_din   = write_a ? data_a_reg : '0;
    assign outB_din   = write_b ? data_b_reg : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_READ;
            data_a_reg <= '0;
            data_b_reg <= '0;
            sent_a_reg <= 1'b0;
            sent_b_reg <= 1'b0;
        end else if (capture) begin
            state_reg  <= S_WRITE;
            data_a_reg <= in_dout;
            data_b_reg <= branch_b_value;
            sent_a_reg <= 1'b0;
            sent_b_reg <= 1'b0;
        end else if (state_reg == S_WRITE) begin
            // Reaching here with done set means the input ran dry: go idle.
            if (done) begin
                state_reg <= S_READ;
            end
            sent_a_reg <= sent_a_reg || write_a;
            sent_b_reg <= sent_b_reg || write_b;
        end
    end

endmodule
